// File: rtl/prio_enc_rr_if.sv
// Request/result handshake bundle for prio_enc_rr.
// The producer/consumer side uses master; the encoder uses slave.
interface prio_enc_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] idx;
  logic         multi;
  logic         none;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req,
    output in_valid,
    input  in_ready,
    input  idx,
    input  multi,
    input  none,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  req,
    input  in_valid,
    output in_ready,
    output idx,
    output multi,
    output none,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshakes.
// Fixed priority (bit 0 highest) or round-robin from an internal pointer.
// Reports multi-hot and all-zero requests; one result register, no input buffer.
module prio_enc_rr #(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  prio_enc_rr_if.slave bus
);
  localparam int W = $clog2(N);

  logic         out_valid_q;
  logic [W-1:0] idx_q;
  logic         multi_q;
  logic         none_q;
  logic [W-1:0] ptr_q;

  logic         in_ready_c;
  logic         accept;
  logic [N-1:0] rr_mask;
  logic [N-1:0] rr_req;
  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [W-1:0] ptr_nxt;
  logic         multi_c;
  logic         none_c;

  // Index of the lowest set bit of v, 0 when v is all zeros.
  function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[N-1-i]) r = W'(N - 1 - i);
    end
    return r;
  endfunction

  // Handshake: accept whenever the result slot is free or being drained.
  always_comb begin
    in_ready_c = ~out_valid_q | bus.out_ready;
    accept     = bus.in_valid & in_ready_c;
  end

  // Winner selection; the round-robin wrap is done by first searching bits at
  // or above ptr and falling back to the plain lowest bit when none are set.
  always_comb begin
    rr_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_mask[i] = (W'(i) >= ptr_q);
    end
    rr_req    = bus.req & rr_mask;
    fixed_idx = lowest_set(bus.req);
    rr_idx    = (|rr_req) ? lowest_set(rr_req) : fixed_idx;
    win_idx   = (RR_MODE != 0) ? rr_idx : fixed_idx;
    ptr_nxt   = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
    none_c    = ~|bus.req;
    multi_c   = |(bus.req & (bus.req - N'(1)));
  end

  // Result register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      multi_q     <= 1'b0;
      none_q      <= 1'b0;
      ptr_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      idx_q       <= none_c ? '0 : win_idx;
      multi_q     <= multi_c;
      none_q      <= none_c;
      if ((RR_MODE != 0) && !none_c) ptr_q <= ptr_nxt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.multi     = multi_q;
  assign bus.none      = none_q;
endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: three instances (fixed N=8, RR N=8, RR N=5) checked
// by a scoreboard fed from a behavioural model of the encoder rules.
module tb_prio_enc_rr;
  localparam int NI = 3;
  localparam int NS  [NI] = '{8, 8, 5};
  localparam int RRS [NI] = '{0, 1, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req_d  [NI];
  logic       inv_d  [NI];
  logic       ordy_d [NI];
  logic [7:0] idx_o  [NI];
  logic       multi_o[NI];
  logic       none_o [NI];
  logic       ov_o   [NI];
  logic       ir_o   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NN = NS[g];
    localparam int RR = RRS[g];
    prio_enc_rr_if #(.N(NN)) bus ();
    assign bus.req       = req_d[g][NN-1:0];
    assign bus.in_valid  = inv_d[g];
    assign bus.out_ready = ordy_d[g];
    assign idx_o[g]      = 8'(bus.idx);
    assign multi_o[g]    = bus.multi;
    assign none_o[g]     = bus.none;
    assign ov_o[g]       = bus.out_valid;
    assign ir_o[g]       = bus.in_ready;
    prio_enc_rr #(.N(NN), .RR_MODE(RR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  typedef struct packed {
    logic [7:0] idx;
    logic       multi;
    logic       none;
  } exp_t;

  exp_t        sbq [NI][$];
  bit          occ [NI];
  int unsigned ptr [NI];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[inst %0d]: got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: on every accept, work out the winner from the rules
  // (count set bits, scan from ptr modulo N) and push it to the scoreboard.
  always @(posedge clk or negedge rst_n) begin
    exp_t        e;
    int unsigned cnt, n, b;
    bit          acc, found;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        sbq[i].delete();
        occ[i] = 1'b0;
        ptr[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        acc = inv_d[i] && (!occ[i] || ordy_d[i]);
        if (acc) begin
          n   = NS[i];
          cnt = 0;
          for (int unsigned k = 0; k < n; k++) cnt += req_d[i][k];
          e = '0;
          if (cnt == 0) begin
            e.none = 1'b1;
          end else begin
            e.multi = (cnt > 1);
            found = 1'b0;
            for (int unsigned k = 0; k < n; k++) begin
              b = (RRS[i] != 0) ? (ptr[i] + k) % n : k;
              if (!found && req_d[i][b]) begin
                found = 1'b1;
                e.idx = 8'(b);
              end
            end
            if (RRS[i] != 0) ptr[i] = (int'(e.idx) + 1) % n;
          end
          sbq[i].push_back(e);
        end
        occ[i] = acc || (occ[i] && !ordy_d[i]);
      end
    end
  end

  // Monitor: compares handshake state each cycle, and the presented result
  // against the scoreboard head; pops on transfer. Also checks reset is immediate.
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      #1;
      for (int i = 0; i < NI; i++) begin
        chk("rst_out_valid", i, int'(ov_o[i]), 0);
        chk("rst_idx", i, int'(idx_o[i]), 0);
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        chk("out_valid", i, int'(ov_o[i]), int'(occ[i]));
        chk("in_ready", i, int'(ir_o[i]), int'(!occ[i] || ordy_d[i]));
        if (ov_o[i]) begin
          if (sbq[i].size() == 0) begin
            chk("sb_size", i, 0, 1);
          end else begin
            e = sbq[i][0];
            chk("idx", i, int'(idx_o[i]), int'(e.idx));
            chk("multi", i, int'(multi_o[i]), int'(e.multi));
            chk("none", i, int'(none_o[i]), int'(e.none));
            if (ordy_d[i]) void'(sbq[i].pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set(input int i, input logic [7:0] r, input logic v, input logic o);
    req_d[i]  = r;
    inv_d[i]  = v;
    ordy_d[i] = o;
  endtask

  initial begin
    logic [7:0] r, m;
    for (int i = 0; i < NI; i++) set(i, 8'h00, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();

    // single request, multi-hot, all-zero on the fixed encoder
    set(0, 8'h04, 1, 1); cyc();
    set(0, 8'h00, 0, 1); cyc(); cyc();
    set(0, 8'hA0, 1, 1); cyc();
    set(0, 8'h00, 1, 1); cyc();
    set(0, 8'h00, 0, 1); cyc(); cyc();

    // round-robin sweep with an all-zero request mid-stream
    set(1, 8'hFF, 1, 1); repeat (9) cyc();
    set(1, 8'h00, 1, 1); cyc();
    set(1, 8'hFF, 1, 1); repeat (3) cyc();
    set(1, 8'h00, 0, 1); cyc(); cyc();

    // backpressure with changing req, then simultaneous transfer and accept
    set(0, 8'h08, 1, 1); cyc();
    set(0, 8'h10, 1, 0); cyc();
    set(0, 8'h20, 1, 0); cyc();
    set(0, 8'h40, 1, 0); cyc();
    set(0, 8'h03, 1, 1); cyc();
    set(0, 8'h00, 0, 1); cyc(); cyc();

    // non-power-of-two round-robin wrap
    set(2, 8'h10, 1, 1); cyc();
    set(2, 8'h11, 1, 1); cyc(); cyc();
    set(2, 8'h00, 0, 1); cyc(); cyc();

    // async reset while a result is held and ptr=3
    set(1, 8'h04, 1, 1); cyc();
    set(1, 8'h00, 0, 0); cyc();
    #1 rst_n = 1'b0;
    #4;
    @(posedge clk);
    #2 rst_n = 1'b1;
    set(1, 8'hFF, 1, 1); cyc();
    set(1, 8'h00, 0, 1); cyc(); cyc();

    // randomized traffic on all instances
    repeat (400) begin
      for (int i = 0; i < NI; i++) begin
        r = 8'($urandom);
        if ($urandom_range(0, 3) == 0) r = 8'h00;
        m = 8'((1 << NS[i]) - 1);
        set(i, r & m, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
      end
      cyc();
    end

    for (int i = 0; i < NI; i++) set(i, 8'h00, 1'b0, 1'b1);
    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
